// File: rtl/ram_pkg.sv
// Shared encodings for the synchronous MAS-sized data RAM.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ram_pkg;

  // Memory access size encodings; 2'b11 is the illegal size.
  localparam logic [1:0] MAS_BYTE = 2'b00;
  localparam logic [1:0] MAS_HALF = 2'b01;
  localparam logic [1:0] MAS_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Request fields captured on the accepting edge (address kept separately
  // because its width is a module parameter).
  typedef struct packed {
    logic        rd;
    logic        sgn;
    logic [1:0]  mas;
    logic [31:0] din;
  } req_t;

  // Number of bytes touched by an access. The illegal size reports 1 so the
  // range arithmetic stays well defined; it faults on its own anyway.
  function automatic logic [2:0] mas_size(input logic [1:0] mas);
    case (mas)
      MAS_BYTE: return 3'd1;
      MAS_HALF: return 3'd2;
      MAS_WORD: return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/ram_sync_mas_lane_fmt.sv
// Big-endian lane formatting: packs/extends read bytes, splits write data into lanes.
// Latency: purely combinational.
// Backpressure: none; driven by the captured request of the parent FSM.
// Ports: mas/signed_load select format; rd_raw = {mem[a],mem[a+1],mem[a+2],mem[a+3]};
//        wr_data right-justified in; rd_data out; wr_lane/wr_be use the same
//        lane order as rd_raw (bit 3 of wr_be / bits 31:24 are lane mem[a]).
module ram_lane_fmt
  import ram_pkg::*;
(
  input  logic [1:0]  mas,
  input  logic        signed_load,
  input  logic [31:0] rd_raw,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [31:0] wr_lane,
  output logic [3:0]  wr_be
);

  logic ext;

  always_comb begin
    rd_data = 32'd0;
    wr_lane = 32'd0;
    wr_be   = 4'b0000;
    ext     = 1'b0;
    case (mas)
      MAS_BYTE: begin
        ext     = signed_load & rd_raw[31];
        rd_data = {{24{ext}}, rd_raw[31:24]};
        wr_lane = {wr_data[7:0], 24'd0};
        wr_be   = 4'b1000;
      end
      MAS_HALF: begin
        ext     = signed_load & rd_raw[31];
        rd_data = {{16{ext}}, rd_raw[31:16]};
        wr_lane = {wr_data[15:0], 16'd0};
        wr_be   = 4'b1100;
      end
      MAS_WORD: begin
        rd_data = rd_raw;
        wr_lane = wr_data;
        wr_be   = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_sync_mas.sv
// Clocked byte-addressable data RAM with MAS sizing, signed loads and faults.
// Latency: done rises N+1 edges after the accepting edge (N = wait count for MAS).
// Backpressure: four-phase enable/done; done held until enable falls, new request only from IDLE.
// Ports: clk, reset (sync, active-high); enable/readWrite/signedLoad/MAS/address/dataIn
//        request; dataOut (held between reads), done, busy (WAIT/DONE), fault (valid with done).
module ram_sync_mas
  import ram_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_B      = 1,
  parameter int WAIT_H      = 2,
  parameter int WAIT_W      = 3,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              readWrite,
  input  logic              signedLoad,
  input  logic [1:0]        MAS,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       dataIn,
  output logic [31:0]       dataOut,
  output logic              done,
  output logic              busy,
  output logic              fault
);

  localparam int WMAX  = (WAIT_B > WAIT_H) ? ((WAIT_B > WAIT_W) ? WAIT_B : WAIT_W)
                                           : ((WAIT_H > WAIT_W) ? WAIT_H : WAIT_W);
  localparam int CNT_W = (WMAX < 1) ? 1 : $clog2(WMAX + 1);

  logic [7:0] mem [DEPTH];

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_load;
  req_t              req, req_n;
  logic [ADDR_W-1:0] req_addr, addr_n;
  logic              done_n, fault_n, wr_go;
  logic [31:0]       dout_n;

  logic [31:0]       rd_raw, rd_data, wr_lane;
  logic [3:0]        wr_be;
  logic [2:0]        size_m1;
  logic [ADDR_W:0]   last_byte;
  logic              acc_fault;

  // Wait count for the size being requested right now (used on accept only).
  always_comb begin
    case (MAS)
      MAS_BYTE: cnt_load = CNT_W'(WAIT_B);
      MAS_HALF: cnt_load = CNT_W'(WAIT_H);
      MAS_WORD: cnt_load = CNT_W'(WAIT_W);
      default:  cnt_load = '0;
    endcase
  end

  // Fetch all four candidate bytes; lanes past the access size are ignored by
  // the formatter, so wrapped indices here are harmless.
  assign rd_raw = {mem[req_addr], mem[req_addr + ADDR_W'(1)],
                   mem[req_addr + ADDR_W'(2)], mem[req_addr + ADDR_W'(3)]};

  ram_lane_fmt u_lane_fmt (
    .mas         (req.mas),
    .signed_load (req.sgn),
    .rd_raw      (rd_raw),
    .wr_data     (req.din),
    .rd_data     (rd_data),
    .wr_lane     (wr_lane),
    .wr_be       (wr_be)
  );

  // The extra top bit makes an overrun past the last byte visible instead of
  // wrapping back to address 0.
  assign size_m1   = mas_size(req.mas) - 3'd1;
  assign last_byte = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, size_m1};

  always_comb begin
    acc_fault = 1'b0;
    if (req.mas == 2'b11)
      acc_fault = 1'b1;
    if (ALIGN_CHECK != 0) begin
      if ((req.mas == MAS_HALF) && req_addr[0])
        acc_fault = 1'b1;
      if ((req.mas == MAS_WORD) && (req_addr[1:0] != 2'b00))
        acc_fault = 1'b1;
    end
    if (last_byte > {1'b0, {ADDR_W{1'b1}}})
      acc_fault = 1'b1;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req;
    addr_n  = req_addr;
    done_n  = done;
    fault_n = fault;
    dout_n  = dataOut;
    wr_go   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          req_n   = '{rd: readWrite, sgn: signedLoad, mas: MAS, din: dataIn};
          addr_n  = address;
          cnt_n   = cnt_load;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          done_n  = 1'b1;
          fault_n = acc_fault;
          if (!acc_fault) begin
            if (req.rd) dout_n = rd_data;
            else        wr_go  = 1'b1;
          end
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          done_n  = 1'b0;
          fault_n = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      req      <= '0;
      req_addr <= '0;
      done     <= 1'b0;
      fault    <= 1'b0;
      dataOut  <= 32'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      req      <= req_n;
      req_addr <= addr_n;
      done     <= done_n;
      fault    <= fault_n;
      dataOut  <= dout_n;
    end
  end

  // Storage is never cleared; a reset on the completing edge drops the write.
  always_ff @(posedge clk) begin
    if (wr_go && !reset) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[3-k])
          mem[req_addr + ADDR_W'(k)] <= wr_lane[31-8*k -: 8];
      end
    end
  end

  assign busy = (state == ST_WAIT) || (state == ST_DONE);

endmodule

// File: tb/tb_ram_sync_mas.sv
module tb_ram_sync_mas;

  logic        clk = 1'b0;
  logic        reset;
  logic        en [2];
  logic        rw, sgn;
  logic [1:0]  mas;
  logic [8:0]  addr;
  logic [31:0] din;
  logic [31:0] dout [2];
  logic        done [2];
  logic        busy [2];
  logic        fault [2];

  int total = 0;
  int bad   = 0;

  logic [7:0]  mm [2][512];
  logic [31:0] mdout [2];
  logic [31:0] g;

  always #5 clk = ~clk;

  // Instance 0: default timing, alignment checked.
  ram_sync_mas #(.DEPTH(512), .ADDR_W(9), .WAIT_B(1), .WAIT_H(2), .WAIT_W(3), .ALIGN_CHECK(1)) dut (
    .clk(clk), .reset(reset), .enable(en[0]), .readWrite(rw), .signedLoad(sgn), .MAS(mas),
    .address(addr), .dataIn(din), .dataOut(dout[0]), .done(done[0]), .busy(busy[0]), .fault(fault[0]));

  // Instance 1: swept wait states, unaligned access allowed.
  ram_sync_mas #(.DEPTH(512), .ADDR_W(9), .WAIT_B(0), .WAIT_H(2), .WAIT_W(5), .ALIGN_CHECK(0)) dut2 (
    .clk(clk), .reset(reset), .enable(en[1]), .readWrite(rw), .signedLoad(sgn), .MAS(mas),
    .address(addr), .dataIn(din), .dataOut(dout[1]), .done(done[1]), .busy(busy[1]), .fault(fault[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int s, input logic [1:0] m);
    int tb0 [4] = '{1, 2, 3, 0};
    int tb1 [4] = '{0, 2, 5, 0};
    return (s == 0) ? tb0[m] : tb1[m];
  endfunction

  // One full four-phase access on instance s, checked against the byte-array model.
  task automatic access(input int s, input bit rw_i, input bit sgn_i, input logic [1:0] mas_i,
                        input int a, input logic [31:0] d, input bit drop, output logic [31:0] got);
    int          size, lat, exp_lat;
    bit          seen, exp_f;
    logic [31:0] v, exp_d;

    size  = (mas_i == 2'd0) ? 1 : (mas_i == 2'd1) ? 2 : (mas_i == 2'd2) ? 4 : 0;
    exp_f = (mas_i == 2'd3) || (a + size - 1 >= 512);
    if (s == 0 && ((mas_i == 2'd1 && a % 2 != 0) || (mas_i == 2'd2 && a % 4 != 0)))
      exp_f = 1'b1;
    exp_lat = wait_of(s, mas_i) + 1;
    exp_d   = mdout[s];
    if (!exp_f && rw_i) begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = (v << 8) | 32'(mm[s][a + i]);
      if (sgn_i && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      exp_d = v;
    end

    @(negedge clk);
    rw = rw_i; sgn = sgn_i; mas = mas_i; addr = 9'(a); din = d; en[s] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    // Scramble inputs while busy; only the captured request may matter.
    rw = 1'($urandom); sgn = 1'($urandom); mas = 2'($urandom); addr = 9'($urandom); din = $urandom;
    if (drop) en[s] = 1'b0;

    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done[s]) seen = 1'b1;
      else chk("busy_wait", 32'(busy[s]), 32'd1);
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", lat, exp_lat);
    chk("fault", 32'(fault[s]), 32'(exp_f));
    chk("dataOut", dout[s], exp_d);
    chk("busy_done", 32'(busy[s]), 32'd1);
    got = dout[s];

    if (!drop) begin
      @(posedge clk); #1;
      chk("done_hold", 32'(done[s]), 32'd1);
      chk("fault_hold", 32'(fault[s]), 32'(exp_f));
      chk("dout_hold", dout[s], exp_d);
    end
    @(negedge clk); en[s] = 1'b0;
    @(posedge clk); #1;
    chk("done_clr", 32'(done[s]), 32'd0);
    chk("busy_clr", 32'(busy[s]), 32'd0);
    chk("fault_clr", 32'(fault[s]), 32'd0);

    mdout[s] = exp_d;
    if (!exp_f && !rw_i)
      for (int i = 0; i < size; i++) mm[s][a + i] = d[8*(size-1-i) +: 8];
  endtask

  initial begin
    reset = 1'b1; en[0] = 1'b0; en[1] = 1'b0;
    rw = 1'b1; sgn = 1'b0; mas = 2'd0; addr = 9'd0; din = 32'd0;
    mdout[0] = 32'd0; mdout[1] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_dout", dout[s], 32'd0);
      chk("rst_done", 32'(done[s]), 32'd0);
      chk("rst_busy", 32'(busy[s]), 32'd0);
      chk("rst_fault", 32'(fault[s]), 32'd0);
    end
    @(negedge clk); reset = 1'b0;

    // Give every byte a known value.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 128; w++) access(s, 1'b0, 1'b0, 2'd2, w * 4, $urandom, 1'b0, g);

    // Word write/read, byte from inside the word.
    access(0, 1'b0, 1'b0, 2'd2, 'h010, 32'hDEADBEEF, 1'b0, g);
    access(0, 1'b1, 1'b0, 2'd2, 'h010, 32'd0, 1'b0, g);  chk("word_rd", g, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 2'd0, 'h011, 32'd0, 1'b0, g);  chk("byte_rd", g, 32'h000000AD);

    // Signed loads.
    access(0, 1'b0, 1'b0, 2'd0, 'h020, 32'h00000080, 1'b0, g);
    access(0, 1'b1, 1'b1, 2'd0, 'h020, 32'd0, 1'b0, g);  chk("sbyte", g, 32'hFFFFFF80);
    access(0, 1'b1, 1'b0, 2'd0, 'h020, 32'd0, 1'b0, g);  chk("ubyte", g, 32'h00000080);
    access(0, 1'b0, 1'b0, 2'd1, 'h022, 32'h00008001, 1'b0, g);
    access(0, 1'b1, 1'b1, 2'd1, 'h022, 32'd0, 1'b0, g);  chk("shalf", g, 32'hFFFF8001);

    // Faults: misaligned word, illegal size, overrun write.
    access(0, 1'b1, 1'b0, 2'd2, 'h013, 32'd0, 1'b0, g);  chk("mis_keep", g, 32'hFFFF8001);
    access(0, 1'b1, 1'b0, 2'd3, 'h000, 32'd0, 1'b0, g);
    access(0, 1'b0, 1'b0, 2'd2, 'h1FE, 32'h12345678, 1'b0, g);
    access(0, 1'b1, 1'b0, 2'd1, 'h1FE, 32'd0, 1'b0, g);

    // enable dropped during WAIT still completes.
    access(0, 1'b1, 1'b0, 2'd2, 'h010, 32'd0, 1'b1, g);  chk("drop_rd", g, 32'hDEADBEEF);

    // Swept wait states, unaligned allowed, range fault without alignment fault.
    access(1, 1'b1, 1'b0, 2'd0, 'h005, 32'd0, 1'b0, g);
    access(1, 1'b0, 1'b0, 2'd2, 'h013, 32'hCAFEF00D, 1'b0, g);
    access(1, 1'b1, 1'b0, 2'd2, 'h013, 32'd0, 1'b0, g);  chk("unal_rd", g, 32'hCAFEF00D);
    access(1, 1'b0, 1'b0, 2'd2, 'h1FE, 32'h87654321, 1'b0, g);
    access(1, 1'b1, 1'b0, 2'd1, 'h1FE, 32'd0, 1'b0, g);

    // Reset during the WAIT of a word write: nothing committed.
    @(negedge clk);
    rw = 1'b0; sgn = 1'b0; mas = 2'd2; addr = 9'h040; din = 32'h55AA55AA; en[0] = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy[0]), 32'd1);
    @(negedge clk); reset = 1'b1; en[0] = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      chk("mid_dout", dout[s], 32'd0);
      chk("mid_done", 32'(done[s]), 32'd0);
      chk("mid_busy0", 32'(busy[s]), 32'd0);
      chk("mid_fault", 32'(fault[s]), 32'd0);
      mdout[s] = 32'd0;
    end
    @(negedge clk); reset = 1'b0;
    access(0, 1'b1, 1'b0, 2'd2, 'h040, 32'd0, 1'b0, g);

    // Random traffic on both instances.
    for (int n = 0; n < 200; n++)
      access(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)),
             int'($urandom_range(0, 511)), $urandom, ($urandom_range(0, 7) == 0), g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
